apb_master_nslv: RTL and testbench

APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

---
 rtl/apb_master_nslv_if.sv | 45 ++++
 rtl/apb_master_nslv.sv | 135 +++++++++++++
 tb/tb_apb_master_nslv.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_nslv_if.sv
// Request/response and APB bus bundle for apb_master_nslv.
// master: the bridge's view. slave: the environment's view (requester plus APB slaves).
interface apb_master_nslv_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NSLV   = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // Request/response side
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDR_W-1:0]        req_addr;
    logic [DATA_W-1:0]        req_wdata;
    logic [STRB_W-1:0]        req_strb;
    logic                     rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;

    // APB side
    logic [NSLV-1:0]          Psel;
    logic                     Penable;
    logic                     Pwrite;
    logic [ADDR_W-1:0]        Paddr;
    logic [DATA_W-1:0]        Pwdata;
    logic [STRB_W-1:0]        Pstrb;
    logic [NSLV*DATA_W-1:0]   Prdata;
    logic [NSLV-1:0]          Pready;
    logic [NSLV-1:0]          Pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output Psel, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Psel, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_master_nslv.sv
// APB master bridging a valid/ready request port onto NSLV APB slaves.
// The slave index is taken from the top address bits.
// Optional build macro: APB_MASTER_TIMEOUT_EN -- aborts an ACCESS phase
// with an error response after TIMEOUT_CYC not-ready cycles.
module apb_master_nslv #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NSLV        = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                Pclk,
    input  logic                Presetn,
    apb_master_nslv_if.master   bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SB     = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             state;
    logic               err_pend;
    logic [SB-1:0]      req_idx;
    logic               req_idx_ok;
    logic               req_ready_c;
    logic               go_setup;
    logic               bad_accept;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [TO_W-1:0]    to_cnt;
`else
    // TIMEOUT_CYC has no effect unless the timeout build is selected.
    if (TIMEOUT_CYC == 0) begin : g_timeout_unused
    end
`endif

    // Address decode, selected-slave response mux and request handshake.
    always_comb begin
        req_idx     = bus.req_addr[ADDR_W-1 -: SB];
        req_idx_ok  = (32'(req_idx) < NSLV);
        sel_ready   = |(bus.Pready  & bus.Psel);
        sel_err     = |(bus.Pslverr & bus.Psel);
        sel_rdata   = '0;
        for (int k = 0; k < int'(NSLV); k++) begin
            if (bus.Psel[k]) begin
                sel_rdata = sel_rdata | bus.Prdata[k*DATA_W +: DATA_W];
            end
        end
        req_ready_c = (state == IDLE) || ((state == ACCESS) && sel_ready);
        go_setup    = bus.req_valid && req_ready_c && req_idx_ok;
        bad_accept  = bus.req_valid && req_ready_c && !req_idx_ok;
    end

    assign bus.req_ready = req_ready_c;

    // FSM with registered APB and response outputs.
    // A decode error accepted at a completion edge cannot share that edge's
    // response pulse, so it is parked in err_pend and issued one cycle later.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state         <= IDLE;
            err_pend      <= 1'b0;
            bus.Psel      <= '0;
            bus.Penable   <= 1'b0;
            bus.Pwrite    <= 1'b0;
            bus.Paddr     <= '0;
            bus.Pwdata    <= '0;
            bus.Pstrb     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    bus.rsp_valid <= err_pend || bad_accept;
                    bus.rsp_err   <= err_pend || bad_accept;
                    err_pend      <= err_pend && bad_accept;
                end
                SETUP: begin
                    bus.Penable <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                end
                ACCESS: begin
                    if (sel_ready) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= sel_err;
                        bus.rsp_rdata <= bus.Pwrite ? '0 : sel_rdata;
                        bus.Penable   <= 1'b0;
                        bus.Psel      <= '0;
                        err_pend      <= bad_accept;
                        state         <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.Penable   <= 1'b0;
                        bus.Psel      <= '0;
                        state         <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
            // Launch of a decodable request, from IDLE or back-to-back from ACCESS.
            if (go_setup) begin
                bus.Psel    <= NSLV'(1) << req_idx;
                bus.Penable <= 1'b0;
                bus.Pwrite  <= bus.req_write;
                bus.Paddr   <= bus.req_addr;
                bus.Pwdata  <= bus.req_write ? bus.req_wdata : '0;
                bus.Pstrb   <= bus.req_write ? bus.req_strb  : '0;
                state       <= SETUP;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_nslv.sv
// Directed bench for apb_master_nslv (three slaves, 32-bit bus).
module tb_apb_master_nslv;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NSLV   = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic Pclk;
    logic Presetn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    apb_master_nslv_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) bus ();

    apb_master_nslv #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .TIMEOUT_CYC(4)
    ) dut (
        .Pclk(Pclk),
        .Presetn(Presetn),
        .bus(bus)
    );

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;
    always @(posedge Pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    task automatic push(input logic [31:0] rdata, input logic err, input int c);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    // Offers a request until accepted; returns the accept cycle, one cycle later.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int acc);
        int waited;
        waited        = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_strb  = s;
        #1;
        while (!bus.req_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("req_accepted", 64'(bus.req_ready), 64'(1'b1));
        acc = cyc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge Pclk) begin
        if (bus.rsp_valid) begin
            chk("rsp_expected", 64'(sb.size() != 0), 64'(1'b1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                chk("rsp_err",   64'(bus.rsp_err),   64'(e.err));
                chk("rsp_cycle", 64'(cyc),           64'(e.cyc));
            end
        end
    end

    initial begin
        int a;
        int a2;
        Presetn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.Pready    = 3'b111;
        bus.Pslverr   = 3'b000;
        bus.Prdata[0*32 +: 32] = 32'hDEAD_BEEF;
        bus.Prdata[1*32 +: 32] = 32'h1234_5678;
        bus.Prdata[2*32 +: 32] = 32'hCAFE_F00D;

        // Reset values
        tick();
        chk("rst_psel",    64'(bus.Psel),      64'(0));
        chk("rst_penable", 64'(bus.Penable),   64'(0));
        chk("rst_paddr",   64'(bus.Paddr),     64'(0));
        chk("rst_pwdata",  64'(bus.Pwdata),    64'(0));
        chk("rst_rsp",     64'(bus.rsp_valid), 64'(0));
        chk("rst_ready",   64'(bus.req_ready), 64'(1));
        tick();
        Presetn = 1'b1;
        tick();

        // Zero-wait write to slave 0; Pslverr from unselected slaves ignored
        bus.Pslverr = 3'b110;
        do_req(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, a);
        push(32'h0, 1'b0, a + 3);
        chk("w_setup_psel",    64'(bus.Psel),    64'(3'b001));
        chk("w_setup_penable", 64'(bus.Penable), 64'(0));
        chk("w_setup_paddr",   64'(bus.Paddr),   64'(32'h10));
        chk("w_setup_pwrite",  64'(bus.Pwrite),  64'(1));
        chk("w_setup_pwdata",  64'(bus.Pwdata),  64'(32'hA5A5_A5A5));
        chk("w_setup_pstrb",   64'(bus.Pstrb),   64'(4'hF));
        tick();
        chk("w_access_penable", 64'(bus.Penable), 64'(1));
        chk("w_access_psel",    64'(bus.Psel),    64'(3'b001));
        tick();
        chk("w_done_psel",    64'(bus.Psel),    64'(0));
        chk("w_done_penable", 64'(bus.Penable), 64'(0));
        bus.Pslverr = 3'b000;

        // Read from slave 1 with two wait states; slave 0 noise ignored
        bus.Pready  = 3'b101;
        bus.Pslverr = 3'b001;
        do_req(1'b0, 32'h4000_0004, 32'hFFFF_FFFF, 4'hF, a);
        push(32'h1234_5678, 1'b0, a + 5);
        chk("r_setup_psel",   64'(bus.Psel),   64'(3'b010));
        chk("r_setup_paddr",  64'(bus.Paddr),  64'(32'h4000_0004));
        chk("r_setup_pwdata", 64'(bus.Pwdata), 64'(0));
        chk("r_setup_pstrb",  64'(bus.Pstrb),  64'(0));
        tick();
        chk("r_wait1_penable", 64'(bus.Penable), 64'(1));
        chk("r_wait1_paddr",   64'(bus.Paddr),   64'(32'h4000_0004));
        tick();
        chk("r_wait2_paddr", 64'(bus.Paddr),     64'(32'h4000_0004));
        chk("r_wait2_psel",  64'(bus.Psel),      64'(3'b010));
        chk("r_wait2_ready", 64'(bus.req_ready), 64'(0));
        tick();
        bus.Pready = 3'b111;
        #1;
        chk("r_ready_hi", 64'(bus.req_ready), 64'(1));
        chk("r_ready_paddr", 64'(bus.Paddr),  64'(32'h4000_0004));
        tick();
        chk("r_done_psel", 64'(bus.Psel), 64'(0));
        bus.Pslverr = 3'b000;

        // Back-to-back write then read on slave 2
        do_req(1'b1, 32'h8000_0000, 32'h1122_3344, 4'h3, a);
        push(32'h0, 1'b0, a + 3);
        chk("b2b_w_psel",  64'(bus.Psel),  64'(3'b100));
        chk("b2b_w_pstrb", 64'(bus.Pstrb), 64'(4'h3));
        do_req(1'b0, 32'h8000_0008, 32'hFFFF_FFFF, 4'hF, a2);
        chk("b2b_accept_cycle", 64'(a2), 64'(a + 2));
        push(32'hCAFE_F00D, 1'b0, a2 + 3);
        chk("b2b_r_setup_penable", 64'(bus.Penable), 64'(0));
        chk("b2b_r_setup_psel",    64'(bus.Psel),    64'(3'b100));
        chk("b2b_r_setup_pwrite",  64'(bus.Pwrite),  64'(0));
        chk("b2b_r_setup_paddr",   64'(bus.Paddr),   64'(32'h8000_0008));
        chk("b2b_r_setup_pwdata",  64'(bus.Pwdata),  64'(0));
        tick();
        chk("b2b_r_access_penable", 64'(bus.Penable), 64'(1));
        tick();
        chk("b2b_done_psel", 64'(bus.Psel), 64'(0));

        // Out-of-range slave index: error response, no bus cycle
        do_req(1'b1, 32'hC000_0000, 32'h5555_5555, 4'hF, a);
        push(32'h0, 1'b1, a + 1);
        chk("dec_psel",    64'(bus.Psel),    64'(0));
        chk("dec_penable", 64'(bus.Penable), 64'(0));
        tick();

        // Slave error on a valid slave
        bus.Pslverr = 3'b010;
        do_req(1'b1, 32'h4000_0020, 32'h0000_00FF, 4'h1, a);
        push(32'h0, 1'b1, a + 3);
        tick();
        tick();
        bus.Pslverr = 3'b000;
        tick();

`ifdef APB_MASTER_TIMEOUT_EN
        // Stuck slave: timeout after four not-ready ACCESS cycles
        bus.Pready = 3'b000;
        do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, a);
        push(32'h0, 1'b1, a + 6);
        tick();
        chk("to_access_penable", 64'(bus.Penable), 64'(1));
        for (int i = 0; i < 4; i++) tick();
        chk("to_psel",    64'(bus.Psel),    64'(0));
        chk("to_penable", 64'(bus.Penable), 64'(0));
        bus.Pready = 3'b111;
        tick();
`endif

        // Reset during ACCESS aborts with no response
        bus.Pready = 3'b110;
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, a);
        tick();
        chk("ra_access_penable", 64'(bus.Penable), 64'(1));
        Presetn = 1'b0;
        #1;
        chk("ra_psel",    64'(bus.Psel),      64'(0));
        chk("ra_penable", 64'(bus.Penable),   64'(0));
        chk("ra_paddr",   64'(bus.Paddr),     64'(0));
        chk("ra_pwrite",  64'(bus.Pwrite),    64'(0));
        chk("ra_rsp",     64'(bus.rsp_valid), 64'(0));
        chk("ra_rdata",   64'(bus.rsp_rdata), 64'(0));
        chk("ra_ready",   64'(bus.req_ready), 64'(1));
        tick();
        bus.Pready = 3'b111;
        tick();
        Presetn = 1'b1;
        tick();
        tick();
        chk("ra_idle_psel", 64'(bus.Psel), 64'(0));
        tick();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
